// File: rtl/data_ram_ls_if.sv
// Request/response bus between the MEM stage and the load/store data RAM.
interface data_ram_ls_if #(
    parameter int unsigned ADDR_WIDTH = 32
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  write_enable;
    logic [1:0]            size;
    logic                  sign_extend;
    logic [ADDR_WIDTH-1:0] address;
    logic [31:0]           in;
    logic                  resp_valid;
    logic                  error;
    logic [31:0]           out;

    // Requester side (MEM stage)
    modport master (
        output req_valid, write_enable, size, sign_extend, address, in,
        input  req_ready, resp_valid, error, out
    );

    // Memory side
    modport slave (
        input  req_valid, write_enable, size, sign_extend, address, in,
        output req_ready, resp_valid, error, out
    );
endinterface

// File: rtl/data_ram_ls.sv
// Single-port data RAM with byte/half/word loads and stores, big-endian lanes,
// one-cycle registered response, alignment/range checks and optional zero fill.
module data_ram_ls #(
    parameter int unsigned DEPTH_WORDS    = 256,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic          clock,
    input  logic          reset,
    data_ram_ls_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned LANES = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    logic [31:0]      mem [DEPTH_WORDS];

    state_t           state;
    logic [IDX_W-1:0] cnt;
    logic             ready;
    logic             resp_valid;
    logic             error;
    logic [31:0]      out;

    logic             accept_c;
    logic [IDX_W-1:0] idx_c;
    logic [1:0]       lane_c;
    logic             range_err_c;
    logic             align_err_c;
    logic             err_c;
    logic [3:0]       wmask_c;
    logic [31:0]      wdata_c;
    logic [31:0]      rd_word_c;
    logic [7:0]       rd_byte_c;
    logic [15:0]      rd_half_c;
    logic [31:0]      load_c;

    assign bus.req_ready  = ready;
    assign bus.resp_valid = resp_valid;
    assign bus.error      = error;
    assign bus.out        = out;

    // Request decode: index, lane, error classification
    always_comb begin
        accept_c    = bus.req_valid & ready;
        idx_c       = bus.address[2 +: IDX_W];
        lane_c      = bus.address[1:0];
        range_err_c = (bus.address >> (IDX_W + 2)) != '0;
        align_err_c = 1'b0;
        case (bus.size)
            SZ_BYTE: align_err_c = 1'b0;
            SZ_HALF: align_err_c = bus.address[0];
            SZ_WORD: align_err_c = (bus.address[1:0] != 2'b00);
            default: align_err_c = 1'b1;
        endcase
        err_c = range_err_c | align_err_c;
    end

    // Store lane mask (bit 3 = lane 0 = bits 31:24) and replicated store data
    always_comb begin
        wmask_c = 4'b0000;
        wdata_c = bus.in;
        case (bus.size)
            SZ_BYTE: begin
                wdata_c = {4{bus.in[7:0]}};
                wmask_c = 4'b1000 >> lane_c;
            end
            SZ_HALF: begin
                wdata_c = {2{bus.in[15:0]}};
                wmask_c = lane_c[1] ? 4'b0011 : 4'b1100;
            end
            SZ_WORD: begin
                wdata_c = bus.in;
                wmask_c = 4'b1111;
            end
            default: begin
                wdata_c = bus.in;
                wmask_c = 4'b0000;
            end
        endcase
    end

    // Load extraction and extension
    always_comb begin
        rd_word_c = mem[idx_c];
        rd_byte_c = rd_word_c[31:24];
        case (lane_c)
            2'd0:    rd_byte_c = rd_word_c[31:24];
            2'd1:    rd_byte_c = rd_word_c[23:16];
            2'd2:    rd_byte_c = rd_word_c[15:8];
            default: rd_byte_c = rd_word_c[7:0];
        endcase
        rd_half_c = lane_c[1] ? rd_word_c[15:0] : rd_word_c[31:16];
        load_c    = rd_word_c;
        case (bus.size)
            SZ_BYTE: load_c = {{24{bus.sign_extend & rd_byte_c[7]}}, rd_byte_c};
            SZ_HALF: load_c = {{16{bus.sign_extend & rd_half_c[15]}}, rd_half_c};
            default: load_c = rd_word_c;
        endcase
    end

    // Array writes: zero fill while clearing, masked lanes on an accepted good store
    always_ff @(posedge clock) begin
        if (state == ST_CLEAR) begin
            mem[cnt] <= '0;
        end else if (accept_c && bus.write_enable && !err_c) begin
            for (int b = 0; b < int'(LANES); b++) begin
                if (wmask_c[b]) begin
                    mem[idx_c][8*b +: 8] <= wdata_c[8*b +: 8];
                end
            end
        end
    end

    // Control FSM with registered ready/response outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= RESET_STATE;
            cnt        <= '0;
            ready      <= 1'b0;
            resp_valid <= 1'b0;
            error      <= 1'b0;
            out        <= '0;
        end else begin
            resp_valid <= 1'b0;
            error      <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    cnt <= cnt + IDX_W'(1);
                    if (cnt == IDX_W'(DEPTH_WORDS - 1)) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    ready <= 1'b1;
                    if (accept_c) begin
                        resp_valid <= 1'b1;
                        error      <= err_c;
                        out        <= (err_c || bus.write_enable) ? 32'd0 : load_c;
                    end
                end
                default: begin
                    state <= RESET_STATE;
                    ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_ram_ls.sv
// Scoreboard bench for data_ram_ls: directed loads/stores, error cases and reset/fill behaviour.
module tb_data_ram_ls;
    logic clock = 1'b0;
    logic reset;
    logic reset2;

    always #5 clock = ~clock;

    data_ram_ls_if #(.ADDR_WIDTH(32)) bus  ();
    data_ram_ls_if #(.ADDR_WIDTH(32)) bus2 ();

    data_ram_ls #(.DEPTH_WORDS(16), .ADDR_WIDTH(32), .CLEAR_ON_RESET(1'b1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    data_ram_ls #(.DEPTH_WORDS(16), .ADDR_WIDTH(32), .CLEAR_ON_RESET(1'b0)) dut_noclr (
        .clock (clock),
        .reset (reset2),
        .bus   (bus2.slave)
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          due;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: pop and compare whenever the DUT presents a response
    exp_t e;
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.resp_valid === 1'b1) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_resp: got err=%0b out=%h, want no response", bus.error, bus.out);
                end else begin
                    e = sbq.pop_front();
                    if (bus.error !== e.err || bus.out !== e.data || cyc != e.due) begin
                        n_bad++;
                        $display("FAIL %s: got err=%0b out=%h cyc=%0d, want err=%0b out=%h cyc=%0d",
                                 e.name, bus.error, bus.out, cyc, e.err, e.data, e.due);
                    end
                end
            end else if (bus.error !== 1'b0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL error_without_resp: got error=%b, want 0", bus.error);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Present one request; expected response is queued for the cycle after accept
    task automatic issue(input string name, input bit we, input bit [1:0] sz, input bit sx,
                         input bit [31:0] addr, input bit [31:0] data,
                         input bit exp_err, input bit [31:0] exp_out, input bit track = 1'b1);
        bus.req_valid    = 1'b1;
        bus.write_enable = we;
        bus.size         = sz;
        bus.sign_extend  = sx;
        bus.address      = addr;
        bus.in           = data;
        chk({name, "_ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clock);
        #1;
        if (track) sbq.push_back('{exp_err, exp_out, cyc, name});
        bus.req_valid = 1'b0;
    endtask

    // Count cycles with ready low, starting at the negedge where reset was released
    task automatic measure_fill(input string name);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk(name, 32'(n), 32'd16);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        reset2 = 1'b1;
        bus.req_valid = 1'b0;
        bus.write_enable = 1'b0;
        bus.size = 2'b10;
        bus.sign_extend = 1'b0;
        bus.address = '0;
        bus.in = '0;
        bus2.req_valid = 1'b0;
        bus2.write_enable = 1'b0;
        bus2.size = 2'b10;
        bus2.sign_extend = 1'b0;
        bus2.address = '0;
        bus2.in = '0;

        repeat (3) @(negedge clock);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_error",      32'(bus.error),      32'd0);
        chk("rst_out",        bus.out,             32'd0);
        chk("rst_ready",      32'(bus.req_ready),  32'd0);
        chk("noclr_rst_ready", 32'(bus2.req_ready), 32'd0);

        // No-fill instance: ready right after the first edge following release
        reset2 = 1'b0;
        @(posedge clock);
        #1;
        chk("noclr_ready", 32'(bus2.req_ready), 32'd1);
        @(negedge clock);

        // 1: fill length then a load of cleared memory
        reset = 1'b0;
        measure_fill("fill_len");
        issue("t1_lw4", 1'b0, 2'b10, 1'b0, 32'd4, 32'd0, 1'b0, 32'h0000_0000);

        // 2: back-to-back stores and loads
        issue("t2_sw4", 1'b1, 2'b10, 1'b0, 32'd4, 32'h0000_000A, 1'b0, 32'd0);
        issue("t2_sw0", 1'b1, 2'b10, 1'b0, 32'd0, 32'h0000_0014, 1'b0, 32'd0);
        issue("t2_lw4", 1'b0, 2'b10, 1'b0, 32'd4, 32'd0, 1'b0, 32'h0000_000A);
        issue("t2_lw0", 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 1'b0, 32'h0000_0014);

        // 3: sub-word loads with sign/zero extension
        issue("t3_sw8",  1'b1, 2'b10, 1'b0, 32'd8,  32'h80FF_7F01, 1'b0, 32'd0);
        issue("t3_lb8",  1'b0, 2'b00, 1'b1, 32'd8,  32'd0, 1'b0, 32'hFFFF_FF80);
        issue("t3_lbu9", 1'b0, 2'b00, 1'b0, 32'd9,  32'd0, 1'b0, 32'h0000_00FF);
        issue("t3_lh10", 1'b0, 2'b01, 1'b1, 32'd10, 32'd0, 1'b0, 32'h0000_7F01);
        issue("t3_lhu8", 1'b0, 2'b01, 1'b0, 32'd8,  32'd0, 1'b0, 32'h0000_80FF);
        issue("t3_lh8",  1'b0, 2'b01, 1'b1, 32'd8,  32'd0, 1'b0, 32'hFFFF_80FF);
        issue("t3_lw8s", 1'b0, 2'b10, 1'b1, 32'd8,  32'd0, 1'b0, 32'h80FF_7F01);

        // 4: sub-word stores merge into a word
        issue("t4_sw12", 1'b1, 2'b10, 1'b0, 32'd12, 32'h1122_3344, 1'b0, 32'd0);
        issue("t4_sb13", 1'b1, 2'b00, 1'b0, 32'd13, 32'hFFFF_FFAB, 1'b0, 32'd0);
        issue("t4_sh14", 1'b1, 2'b01, 1'b0, 32'd14, 32'h1234_BEEF, 1'b0, 32'd0);
        issue("t4_lw12", 1'b0, 2'b10, 1'b0, 32'd12, 32'd0, 1'b0, 32'h11AB_BEEF);

        // 5: rejected requests leave memory untouched
        issue("t5_lw6",   1'b0, 2'b10, 1'b0, 32'd6,  32'd0,         1'b1, 32'd0);
        issue("t5_sh5",   1'b1, 2'b01, 1'b0, 32'd5,  32'h0000_5555, 1'b1, 32'd0);
        issue("t5_sz11",  1'b1, 2'b11, 1'b0, 32'd0,  32'hDEAD_BEEF, 1'b1, 32'd0);
        issue("t5_lw64",  1'b0, 2'b10, 1'b0, 32'd64, 32'd0,         1'b1, 32'd0);
        issue("t5_sw64",  1'b1, 2'b10, 1'b0, 32'd64, 32'hCAFE_F00D, 1'b1, 32'd0);
        issue("t5_lw4",   1'b0, 2'b10, 1'b0, 32'd4,  32'd0, 1'b0, 32'h0000_000A);
        issue("t5_lw0",   1'b0, 2'b10, 1'b0, 32'd0,  32'd0, 1'b0, 32'h0000_0014);
        issue("t5_lw8",   1'b0, 2'b10, 1'b0, 32'd8,  32'd0, 1'b0, 32'h80FF_7F01);

        repeat (3) @(negedge clock);
        chk("t5_drain", 32'(sbq.size()), 32'd0);

        // 6a: reset in cycle 5 of the fill restarts it
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        chk("t6_mid_fill_ready", 32'(bus.req_ready), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        measure_fill("fill_restart");
        issue("t6_sw4", 1'b1, 2'b10, 1'b0, 32'd4, 32'h5A5A_5A5A, 1'b0, 32'd0);

        // 6b: reset with a load response pending drops it at once
        issue("t6_lw_lost", 1'b0, 2'b10, 1'b0, 32'd4, 32'd0, 1'b0, 32'd0, 1'b0);
        chk("t6_pending_valid", 32'(bus.resp_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_reset_drop_valid", 32'(bus.resp_valid), 32'd0);
        chk("t6_reset_drop_ready", 32'(bus.req_ready),  32'd0);
        @(negedge clock);
        reset = 1'b0;
        measure_fill("fill_after_pending");
        issue("t6_lw4_cleared", 1'b0, 2'b10, 1'b0, 32'd4, 32'd0, 1'b0, 32'h0000_0000);
        issue("t6_lw8_cleared", 1'b0, 2'b10, 1'b0, 32'd8, 32'd0, 1'b0, 32'h0000_0000);

        repeat (3) @(negedge clock);
        chk("final_drain", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
